// File: rtl/weight_mem_ctrl.sv
// Weight memory controller: streams config weights into per-neuron memories, then runs a shared read sweep.
// Define WMC_PRETRAINED_EN to drop the load path (weights come from memory init files).
module weight_mem_ctrl #(
    parameter int NUM_WEIGHT = 3,
    parameter int NUM_NEURON = 5,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int NID_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [NID_W-1:0]      cfg_nid,
    input  logic [DATA_W-1:0]     cfg_data,
    input  logic                  cfg_clr,
    output logic                  cfg_err,
    output logic [NUM_NEURON-1:0] wen,
    output logic [ADDR_W-1:0]     wadd,
    output logic [DATA_W-1:0]     win,
    output logic                  loaded,
    input  logic                  start,
    output logic                  busy,
    output logic                  ren,
    output logic [ADDR_W-1:0]     radd,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic                  done
);

    localparam int CNT_W = $clog2(NUM_WEIGHT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e              state_q;
    logic                ren_q;
    logic [ADDR_W-1:0]   radd_q;
    logic                rd_valid_q;
    logic                rd_last_q;
    logic                done_q;
    logic                loaded_w;

    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign ren      = ren_q;
    assign radd     = radd_q;
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign done     = done_q;

    // The read pipeline is ren delayed by one cycle, so rd_last/done land in DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ren_q      <= 1'b0;
            radd_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rd_valid_q <= ren_q;
            rd_last_q  <= ren_q && (radd_q == LAST_ADDR);
            done_q     <= ren_q && (radd_q == LAST_ADDR);
            case (state_q)
                IDLE: begin
                    if (start && loaded_w) begin
                        state_q <= RUN;
                        ren_q   <= 1'b1;
                        radd_q  <= '0;
                    end
                end
                RUN: begin
                    if (radd_q == LAST_ADDR) begin
                        state_q <= DRAIN;
                        ren_q   <= 1'b0;
                    end else begin
                        radd_q <= radd_q + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ren_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef WMC_PRETRAINED_EN

    logic unused_cfg;
    assign unused_cfg = ^{cfg_valid, cfg_nid, cfg_data, cfg_clr};

    assign cfg_ready = 1'b0;
    assign cfg_err   = 1'b0;
    assign wen       = '0;
    assign wadd      = '0;
    assign win       = '0;
    assign loaded    = 1'b1;
    assign loaded_w  = 1'b1;

`else

    logic [CNT_W-1:0]      cnt_q [NUM_NEURON];
    logic [CNT_W-1:0]      cnt_d [NUM_NEURON];
    logic [NUM_NEURON-1:0] wen_q;
    logic [NUM_NEURON-1:0] wen_d;
    logic [ADDR_W-1:0]     wadd_q;
    logic [DATA_W-1:0]     win_q;
    logic                  cfg_err_q;
    logic                  loaded_q;

    logic                  xfer;
    logic                  clr;
    logic                  nid_ok;
    logic [CNT_W-1:0]      sel_cnt;
    logic                  accept;
    logic                  drop;
    logic                  all_full;

    assign cfg_ready = (state_q == IDLE);
    assign cfg_err   = cfg_err_q;
    assign wen       = wen_q;
    assign wadd      = wadd_q;
    assign win       = win_q;
    assign loaded    = loaded_q;
    assign loaded_w  = loaded_q;

    assign xfer   = cfg_valid && cfg_ready;
    assign clr    = cfg_clr && (state_q == IDLE);
    assign nid_ok = {1'b0, cfg_nid} < (NID_W + 1)'(NUM_NEURON);
    assign accept = xfer && !clr && nid_ok && (sel_cnt != CNT_W'(NUM_WEIGHT));
    assign drop   = xfer && !clr && !accept;

    // A clear wins over a same-cycle transfer; the transfer is simply lost.
    always_comb begin
        sel_cnt  = '0;
        wen_d    = '0;
        all_full = 1'b1;
        for (int n = 0; n < NUM_NEURON; n++) begin
            cnt_d[n] = cnt_q[n];
            if (cfg_nid == NID_W'(n)) begin
                sel_cnt = cnt_q[n];
            end
            all_full = all_full && (cnt_q[n] == CNT_W'(NUM_WEIGHT));
        end
        for (int n = 0; n < NUM_NEURON; n++) begin
            if (clr) begin
                cnt_d[n] = '0;
            end else if (accept && (cfg_nid == NID_W'(n))) begin
                cnt_d[n] = cnt_q[n] + CNT_W'(1);
                wen_d[n] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_NEURON; n++) begin
                cnt_q[n] <= '0;
            end
            wen_q     <= '0;
            wadd_q    <= '0;
            win_q     <= '0;
            cfg_err_q <= 1'b0;
            loaded_q  <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_NEURON; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
            wen_q <= wen_d;
            if (accept) begin
                wadd_q <= ADDR_W'(sel_cnt);
                win_q  <= cfg_data;
            end
            if (clr) begin
                cfg_err_q <= 1'b0;
            end else if (drop) begin
                cfg_err_q <= 1'b1;
            end
            loaded_q <= !clr && all_full;
        end
    end

`endif

endmodule

// File: tb/tb_weight_mem_ctrl.sv
// Randomized self-checking bench for weight_mem_ctrl against a counter-array model of the load
// rules and a cycle-offset model of the read sweep timing.
module tb_weight_mem_ctrl;

    localparam int NW = 3;
    localparam int NN = 5;

    logic          clk;
    logic          rst_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [2:0]    cfg_nid;
    logic [15:0]   cfg_data;
    logic          cfg_clr;
    logic          cfg_err;
    logic [NN-1:0] wen;
    logic [9:0]    wadd;
    logic [15:0]   win;
    logic          loaded;
    logic          start;
    logic          busy;
    logic          ren;
    logic [9:0]    radd;
    logic          rd_valid;
    logic          rd_last;
    logic          done;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    int mcnt [NN];
    bit merr;

    weight_mem_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_nid   (cfg_nid),
        .cfg_data  (cfg_data),
        .cfg_clr   (cfg_clr),
        .cfg_err   (cfg_err),
        .wen       (wen),
        .wadd      (wadd),
        .win       (win),
        .loaded    (loaded),
        .start     (start),
        .busy      (busy),
        .ren       (ren),
        .radd      (radd),
        .rd_valid  (rd_valid),
        .rd_last   (rd_last),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison funnels through here so the pass/total counters stay authoritative.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit allFull();
        bit f = 1'b1;
        for (int n = 0; n < NN; n++) f = f && (mcnt[n] == NW);
        return f;
    endfunction

    task automatic modelReset();
        for (int n = 0; n < NN; n++) mcnt[n] = 0;
        merr = 1'b0;
    endtask

    // One config transfer in IDLE, checked against the counter model on the following cycle.
    task automatic applyStimulus(input int nid, input logic [15:0] data);
        bit ok;
        bit fullBefore;
        int addr;
        fullBefore = allFull();
        ok         = (nid < NN) && (mcnt[nid < NN ? nid : 0] < NW);
        addr       = ok ? mcnt[nid] : 0;
        cfg_valid  = 1'b1;
        cfg_nid    = 3'(nid);
        cfg_data   = data;
        step();
        cfg_valid  = 1'b0;
        if (ok) begin
            mcnt[nid]++;
            checkOutput("wen", 32'(wen), 32'(1 << nid));
            checkOutput("wadd", 32'(wadd), 32'(addr));
            checkOutput("win", 32'(win), 32'(data));
        end else begin
            merr = 1'b1;
            checkOutput("wen_drop", 32'(wen), 32'h0);
        end
        checkOutput("cfg_err", 32'(cfg_err), 32'(merr));
        checkOutput("loaded_lag", 32'(loaded), 32'(fullBefore));
    endtask

    task automatic clearCounters();
        cfg_clr   = 1'b1;
        cfg_valid = 1'b1;
        cfg_nid   = 3'd0;
        cfg_data  = 16'hDEAD;
        step();
        cfg_clr   = 1'b0;
        cfg_valid = 1'b0;
        modelReset();
        checkOutput("clr_wen", 32'(wen), 32'h0);
        checkOutput("clr_err", 32'(cfg_err), 32'h0);
        checkOutput("clr_loaded", 32'(loaded), 32'h0);
        step();
        checkOutput("clr_loaded2", 32'(loaded), 32'h0);
    endtask

    // k counts cycles after the accepting edge: ren 1..NW, rd_valid 2..NW+1, done at NW+1.
    task automatic sweep(input bit hold, inout int nValid);
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        for (int k = 1; k <= NW + 1; k++) begin
            checkOutput($sformatf("ren_k%0d", k), 32'(ren), 32'(k <= NW));
            checkOutput($sformatf("radd_k%0d", k), 32'(radd), 32'(k <= NW ? k - 1 : NW - 1));
            checkOutput($sformatf("rdv_k%0d", k), 32'(rd_valid), 32'(k >= 2));
            checkOutput($sformatf("last_k%0d", k), 32'(rd_last), 32'(k == NW + 1));
            checkOutput($sformatf("done_k%0d", k), 32'(done), 32'(k == NW + 1));
            checkOutput($sformatf("busy_k%0d", k), 32'(busy), 32'h1);
            checkOutput($sformatf("rdy_k%0d", k), 32'(cfg_ready), 32'h0);
            if (rd_valid) nValid++;
            step();
        end
        checkOutput("idle_busy", 32'(busy), 32'h0);
        checkOutput("idle_ren", 32'(ren), 32'h0);
        checkOutput("idle_done", 32'(done), 32'h0);
        checkOutput("idle_radd_hold", 32'(radd), 32'(NW - 1));
    endtask

    initial begin
        int nValid;
        int iter;
        int nid;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_nid   = '0;
        cfg_data  = '0;
        cfg_clr   = 1'b0;
        start     = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_ready", 32'(cfg_ready), 32'h1);
        checkOutput("rst_wen", 32'(wen), 32'h0);
        checkOutput("rst_loaded", 32'(loaded), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_radd", 32'(radd), 32'h0);
        checkOutput("rst_err", 32'(cfg_err), 32'h0);
        step();
        rst_n = 1'b1;

        start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checkOutput("nl_busy", 32'(busy), 32'h0);
            checkOutput("nl_ren", 32'(ren), 32'h0);
            checkOutput("nl_done", 32'(done), 32'h0);
        end
        start = 1'b0;

        // Interleaved load with the reference values 0x0100 + n*3 + i.
        iter = 0;
        while (!allFull() && iter < 500) begin
            nid = $urandom_range(0, NN - 1);
            if (mcnt[nid] < NW) applyStimulus(nid, 16'(16'h0100 + nid * 3 + mcnt[nid]));
            iter++;
        end
        step();
        checkOutput("loaded", 32'(loaded), 32'(allFull()));
        checkOutput("load_err", 32'(cfg_err), 32'h0);

        applyStimulus(2, 16'h0BAD);
        applyStimulus(6, 16'h0BAD);
        clearCounters();

        // Random reload including out-of-range ids and overflow writes.
        iter = 0;
        while (!allFull() && iter < 400) begin
            applyStimulus($urandom_range(0, 7), 16'($urandom));
            iter++;
        end
        step();
        checkOutput("reload_loaded", 32'(loaded), 32'h1);

        nValid = 0;
        sweep(1'b0, nValid);
        checkOutput("single_valid", 32'(nValid), 32'(NW));

        nValid = 0;
        sweep(1'b1, nValid);
        sweep(1'b1, nValid);
        start = 1'b0;
        checkOutput("held_valid", 32'(nValid), 32'(2 * NW));

        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("abort_ren", 32'(ren), 32'h0);
        checkOutput("abort_busy", 32'(busy), 32'h0);
        checkOutput("abort_radd", 32'(radd), 32'h0);
        checkOutput("abort_rdv", 32'(rd_valid), 32'h0);
        checkOutput("abort_loaded", 32'(loaded), 32'h0);
        step();
        rst_n = 1'b1;
        start = 1'b1;
        for (int c = 0; c < NW + 2; c++) begin
            step();
            checkOutput("post_done", 32'(done), 32'h0);
            checkOutput("post_busy", 32'(busy), 32'h0);
            checkOutput("post_loaded", 32'(loaded), 32'(allFull()));
        end
        start = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
